// File: rtl/xform_pkg.sv
// Shared constants for the coordinate transform pipeline: default widths, Mode bit
// positions, zoom unity and the quarter-wave sine table used by the trig lookup.
package xform_pkg;

   localparam int COORD_W_DEF = 8;
   localparam int TRIG_W_DEF  = 9;
   localparam int MODE_ROT    = 0;
   localparam int MODE_ZOOM   = 1;
   localparam int ZOOM_ONE    = 64;
   localparam int ZOOM_SHIFT  = $clog2(ZOOM_ONE);

   // sin(k * 90deg / 64) in Q2.7, k = 0..64; entry 64 is exactly 1.0
   localparam logic [7:0] QSIN [0:64] = '{
      8'd0,   8'd3,   8'd6,   8'd9,   8'd13,  8'd16,  8'd19,  8'd22,
      8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
      8'd49,  8'd52,  8'd55,  8'd58,  8'd60,  8'd63,  8'd66,  8'd68,
      8'd71,  8'd74,  8'd76,  8'd79,  8'd81,  8'd84,  8'd86,  8'd88,
      8'd91,  8'd93,  8'd95,  8'd97,  8'd99,  8'd101, 8'd103, 8'd105,
      8'd106, 8'd108, 8'd110, 8'd111, 8'd113, 8'd114, 8'd116, 8'd117,
      8'd118, 8'd119, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124, 8'd125,
      8'd126, 8'd126, 8'd127, 8'd127, 8'd127, 8'd128, 8'd128, 8'd128,
      8'd128
   };

endpackage

// File: rtl/xform_pipeline_if.sv
// Beat-level bus of the transform pipeline: input beat with its config, output address beat.
interface xform_pipeline_if
   import xform_pkg::*;
#(
   parameter int COORD_W = COORD_W_DEF,
   parameter int ADDR_W  = 16
);

   // A beat moves on a side when its valid and ready are both high at a clock edge
   // (with ENB high); valid must not depend on ready, and a presented beat holds until taken.
   logic               in_valid;
   logic               in_ready;
   logic [COORD_W-1:0] Xcoord;
   logic [COORD_W-1:0] Ycoord;
   logic [COORD_W-1:0] Xcenter;
   logic [COORD_W-1:0] Ycenter;
   logic [7:0]         Zoom;
   logic [7:0]         Angle;
   logic [1:0]         Mode;
   logic               out_valid;
   logic               out_ready;
   logic [ADDR_W-1:0]  xAddr;
   logic [ADDR_W-1:0]  yAddr;
   logic               out_clip;

   modport master (
      output in_valid, Xcoord, Ycoord, Xcenter, Ycenter, Zoom, Angle, Mode, out_ready,
      input  in_ready, out_valid, xAddr, yAddr, out_clip
   );

   modport slave (
      input  in_valid, Xcoord, Ycoord, Xcenter, Ycenter, Zoom, Angle, Mode, out_ready,
      output in_ready, out_valid, xAddr, yAddr, out_clip
   );

endinterface

// File: rtl/xform_trig_lut.sv
// Combinational Angle -> {sin, cos} by quadrant folding of the quarter-wave table.
module xform_trig_lut
   import xform_pkg::*;
#(
   parameter int TRIG_W = TRIG_W_DEF
) (
   input  logic [7:0]               angle_i,
   output logic signed [TRIG_W-1:0] sin_o,
   output logic signed [TRIG_W-1:0] cos_o
);

   logic [6:0]               idx_fwd;
   logic [6:0]               idx_rev;
   logic signed [TRIG_W-1:0] mag_fwd;
   logic signed [TRIG_W-1:0] mag_rev;

   // cos(a) = sin(a + quarter turn), so both outputs share the same two table reads
   always_comb begin
      idx_fwd = {1'b0, angle_i[5:0]};
      idx_rev = 7'd64 - idx_fwd;
      mag_fwd = $signed(TRIG_W'(QSIN[idx_fwd])) <<< (TRIG_W - TRIG_W_DEF);
      mag_rev = $signed(TRIG_W'(QSIN[idx_rev])) <<< (TRIG_W - TRIG_W_DEF);
      sin_o   = mag_fwd;
      cos_o   = mag_rev;
      case (angle_i[7:6])
         2'd0: begin sin_o =  mag_fwd; cos_o =  mag_rev; end
         2'd1: begin sin_o =  mag_rev; cos_o = -mag_fwd; end
         2'd2: begin sin_o = -mag_fwd; cos_o = -mag_rev; end
         2'd3: begin sin_o = -mag_rev; cos_o =  mag_fwd; end
         default: ;
      endcase
   end

endmodule

// File: rtl/xform_pipeline.sv
// Four-stage coordinate transform: shift, rotate, zoom, screen clamp. One beat per cycle,
// a single global stall freezes every stage so beats are never lost or reordered.
module xform_pipeline
   import xform_pkg::*;
#(
   parameter int COORD_W = COORD_W_DEF,
   parameter int ADDR_W  = 16,
   parameter int TRIG_W  = TRIG_W_DEF,
   parameter int SCR_W   = 160,
   parameter int SCR_H   = 120,
   parameter int SCR_CX  = 80,
   parameter int SCR_CY  = 60
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   input  logic          ENB,
   xform_pipeline_if.slave bus
);

   localparam int DW = COORD_W + 1;
   localparam int RW = COORD_W + 2;
   localparam int ZW = COORD_W + 4;
   localparam int PW = DW + TRIG_W + 1;
   localparam int QW = RW + 9;
   localparam int SW = ZW + 1;
   localparam logic signed [SW-1:0] X_MAX = SW'(SCR_W - 1);
   localparam logic signed [SW-1:0] Y_MAX = SW'(SCR_H - 1);
   localparam logic signed [SW-1:0] X_ORG = SW'(SCR_CX);
   localparam logic signed [SW-1:0] Y_ORG = SW'(SCR_CY);

   logic stall;
   logic s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;

   logic signed [DW-1:0]     s1_dx_d, s1_dy_d, s1_dx_q, s1_dy_q;
   logic signed [TRIG_W-1:0] lut_sin, lut_cos, s1_sin_q, s1_cos_q;
   logic [7:0]               s1_zoom_q;
   logic [1:0]               s1_mode_q;

   logic signed [PW-1:0] rot_x, rot_y;
   logic signed [RW-1:0] s2_rx_d, s2_ry_d, s2_rx_q, s2_ry_q;
   logic [7:0]           s2_zoom_q;
   logic                 s2_zen_q;

   logic signed [QW-1:0] zoom_f, zoom_x, zoom_y;
   logic signed [ZW-1:0] s3_zx_d, s3_zy_d, s3_zx_q, s3_zy_q;

   logic signed [SW-1:0] sx, sy;
   logic [ADDR_W-1:0]    s4_x_d, s4_y_d, s4_x_q, s4_y_q;
   logic                 s4_clip_d, s4_clip_q;

   assign stall        = !ENB || (s4_vld_q && !bus.out_ready);
   assign bus.in_ready = !stall;

   assign s1_dx_d = $signed({1'b0, bus.Xcoord}) - $signed({1'b0, bus.Xcenter});
   assign s1_dy_d = $signed({1'b0, bus.Ycoord}) - $signed({1'b0, bus.Ycenter});

   xform_trig_lut #(.TRIG_W(TRIG_W)) u_trig (
      .angle_i (bus.Angle),
      .sin_o   (lut_sin),
      .cos_o   (lut_cos)
   );

   // Operands are sign-extended to the full product width so no partial product overflows
   always_comb begin
      rot_x   = PW'(s1_dx_q) * PW'(s1_cos_q) - PW'(s1_dy_q) * PW'(s1_sin_q);
      rot_y   = PW'(s1_dx_q) * PW'(s1_sin_q) + PW'(s1_dy_q) * PW'(s1_cos_q);
      s2_rx_d = RW'(s1_dx_q);
      s2_ry_d = RW'(s1_dy_q);
      if (s1_mode_q[MODE_ROT]) begin
         s2_rx_d = RW'(rot_x >>> (TRIG_W - 2));
         s2_ry_d = RW'(rot_y >>> (TRIG_W - 2));
      end
   end

   always_comb begin
      zoom_f  = QW'($signed({1'b0, s2_zoom_q}));
      zoom_x  = QW'(s2_rx_q) * zoom_f;
      zoom_y  = QW'(s2_ry_q) * zoom_f;
      s3_zx_d = s2_zen_q ? ZW'(zoom_x >>> ZOOM_SHIFT) : ZW'(s2_rx_q);
      s3_zy_d = s2_zen_q ? ZW'(zoom_y >>> ZOOM_SHIFT) : ZW'(s2_ry_q);
   end

   always_comb begin
      sx        = SW'(s3_zx_q) + X_ORG;
      sy        = SW'(s3_zy_q) + Y_ORG;
      s4_x_d    = ADDR_W'($unsigned(sx));
      s4_y_d    = ADDR_W'($unsigned(sy));
      s4_clip_d = 1'b0;
      if (sx[SW-1]) begin
         s4_x_d    = '0;
         s4_clip_d = 1'b1;
      end else if (sx > X_MAX) begin
         s4_x_d    = ADDR_W'($unsigned(X_MAX));
         s4_clip_d = 1'b1;
      end
      if (sy[SW-1]) begin
         s4_y_d    = '0;
         s4_clip_d = 1'b1;
      end else if (sy > Y_MAX) begin
         s4_y_d    = ADDR_W'($unsigned(Y_MAX));
         s4_clip_d = 1'b1;
      end
   end

   // Bubbles advance too; data regs of an invalid stage simply carry don't-care values
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         s1_vld_q  <= 1'b0;
         s1_dx_q   <= '0;
         s1_dy_q   <= '0;
         s1_sin_q  <= '0;
         s1_cos_q  <= '0;
         s1_zoom_q <= '0;
         s1_mode_q <= '0;
         s2_vld_q  <= 1'b0;
         s2_rx_q   <= '0;
         s2_ry_q   <= '0;
         s2_zoom_q <= '0;
         s2_zen_q  <= 1'b0;
         s3_vld_q  <= 1'b0;
         s3_zx_q   <= '0;
         s3_zy_q   <= '0;
         s4_vld_q  <= 1'b0;
         s4_x_q    <= '0;
         s4_y_q    <= '0;
         s4_clip_q <= 1'b0;
      end else if (!stall) begin
         s1_vld_q  <= bus.in_valid;
         s1_dx_q   <= s1_dx_d;
         s1_dy_q   <= s1_dy_d;
         s1_sin_q  <= lut_sin;
         s1_cos_q  <= lut_cos;
         s1_zoom_q <= bus.Zoom;
         s1_mode_q <= bus.Mode;
         s2_vld_q  <= s1_vld_q;
         s2_rx_q   <= s2_rx_d;
         s2_ry_q   <= s2_ry_d;
         s2_zoom_q <= s1_zoom_q;
         s2_zen_q  <= s1_mode_q[MODE_ZOOM];
         s3_vld_q  <= s2_vld_q;
         s3_zx_q   <= s3_zx_d;
         s3_zy_q   <= s3_zy_d;
         s4_vld_q  <= s3_vld_q;
         s4_x_q    <= s4_x_d;
         s4_y_q    <= s4_y_d;
         s4_clip_q <= s4_clip_d;
      end
   end

   assign bus.out_valid = s4_vld_q;
   assign bus.xAddr     = s4_x_q;
   assign bus.yAddr     = s4_y_q;
   assign bus.out_clip  = s4_clip_q;

endmodule
